// File: rtl/axis_fifo.sv
// axis_fifo: AXI-Stream beat FIFO with first-word fall-through and registered outputs.
// Data, keep and last are stored together per beat; keep/last are passed through untouched.
// Optional macro AXIS_FIFO_OCCUPANCY_EN adds an `occupancy` output carrying the registered count.
module axis_fifo #(
  parameter  int unsigned WORD_W         = 8,
  parameter  int unsigned BUS_W          = 32,
  parameter  int unsigned DEPTH          = 8,
  localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
  input  logic [WORDS_PER_BEAT-1:0]              s_keep,
  input  logic                                   s_last,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  m_data,
  output logic [WORDS_PER_BEAT-1:0]              m_keep,
  output logic                                   m_last
`ifdef AXIS_FIFO_OCCUPANCY_EN
  ,
  output logic [CNT_W-1:0]                       occupancy
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data_mem [DEPTH];
  logic [WORDS_PER_BEAT-1:0]             keep_mem [DEPTH];
  logic                                  last_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data_q, m_data_d;
  logic [WORDS_PER_BEAT-1:0]             m_keep_q, m_keep_d;
  logic                                  m_last_q, m_last_d;

  logic wr_en;
  logic rd_en;
  logic bypass;

  // Handshakes, pointer/count update and next head-of-queue beat.
  always_comb begin
    wr_en     = s_valid && s_ready_q;
    rd_en     = m_valid_q && m_ready;
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
    count_d   = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != CNT_W'(DEPTH));
    m_valid_d = (count_d != CNT_W'(0));
    // The incoming beat becomes the head when the FIFO is (or becomes) empty this cycle.
    bypass    = wr_en && (count_q == CNT_W'(rd_en));
    if (bypass) begin
      m_data_d = s_data;
      m_keep_d = s_keep;
      m_last_d = s_last;
    end else begin
      m_data_d = data_mem[rd_ptr_d];
      m_keep_d = keep_mem[rd_ptr_d];
      m_last_d = last_mem[rd_ptr_d];
    end
  end

  // Beat storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_q] <= s_data;
      keep_mem[wr_ptr_q] <= s_keep;
      last_mem[wr_ptr_q] <= s_last;
    end
  end

  // Control state and registered output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

`ifdef AXIS_FIFO_OCCUPANCY_EN
  assign occupancy = count_q;
`endif

endmodule
